// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 size/sign codes
//   - FSM state encoding
//   - byte/half lane select and merge helpers (32-bit words)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2
  } lsu_state_e;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] off);
    return w[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] get_half(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] off,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{off, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [31:0] put_half(input logic [31:0] w, input logic hi,
                                           input logic [15:0] h);
    return hi ? {h, w[15:0]} : {w[31:16], h};
  endfunction

  // Stores only know B/H/W; loads add the unsigned variants.
  function automatic logic f3_valid(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   i_funct3   RV32I size/sign code
//   i_off      byte offset within the word (addr[1:0])
//   i_rd       word read from memory
//   i_wdata    low half of the store data (SB uses [7:0], SH uses [15:0])
//   o_ld_data  extracted and sign/zero-extended load result (0 for bad funct3)
//   o_st_word  i_rd with the store byte/half merged in
//   o_misalign natural-alignment violation; only computed when MISALIGN_TRAP_EN
//              is defined, otherwise tied 0 and offsets are truncated
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_rd,
  input  logic [15:0]     i_wdata,
  output logic [XLEN-1:0] o_ld_data,
  output logic [XLEN-1:0] o_st_word,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = get_byte(i_rd, i_off);
  // Halfword lane picked by addr[1] alone: addr[0] is truncated away.
  assign w_half = get_half(i_rd, i_off[1]);

  always_comb begin
    o_ld_data = '0;
    case (i_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'd0, w_half};
      F3_W:    o_ld_data = i_rd;
      default: o_ld_data = '0;
    endcase
  end

  assign o_st_word = (i_funct3 == F3_H) ? put_half(i_rd, i_off[1], i_wdata)
                                        : put_byte(i_rd, i_off, i_wdata[7:0]);

`ifdef MISALIGN_TRAP_EN
  assign o_misalign = (((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && i_off[0]) ||
                      ((i_funct3 == F3_W) && (i_off != 2'b00));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a word-only data-memory port.
// Turns RV32I loads/stores into word-aligned accesses; SB/SH use a
// read-modify-write (ACCESS reads, WRITE writes the merged word).
// Optional feature macro: MISALIGN_TRAP_EN (misaligned H/W requests are
// rejected with rsp_err=1 instead of being truncated to natural alignment).
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid/req_ready      core request handshake
//   req_we/funct3/addr/wdata request fields
//   rsp_valid/rdata/err      one-cycle completion pulse with load data / error
//   mem_we/addr/wd           word-aligned memory write enable, address, data
//   mem_rd                   memory read data (combinational from mem_addr)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wd,
  input  logic [XLEN-1:0]   mem_rd
);

  lsu_state_e        r_state, w_next;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_merged;
  logic              r_rsp_valid;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_st;

  logic [ADDR_W-1:0] w_word_addr;
  logic [XLEN-1:0]   w_ld_data;
  logic [XLEN-1:0]   w_st_word;
  logic              w_misalign;
  logic              w_f3_ok;
  logic              w_err;
  logic              w_do_write;
  logic              w_mem_we;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_funct3   (r_f3),
    .i_off      (r_addr[1:0]),
    .i_rd       (mem_rd),
    .i_wdata    (r_wdata[15:0]),
    .o_ld_data  (w_ld_data),
    .o_st_word  (w_st_word),
    .o_misalign (w_misalign)
  );

  assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_f3_ok     = f3_valid(r_we, r_f3);
  assign w_err       = w_misalign && w_f3_ok;
  assign w_do_write  = r_we && w_f3_ok && !w_err;

  always_comb begin
    w_next   = r_state;
    w_mem_we = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    case (r_state)
      S_IDLE: if (req_valid) w_next = S_ACCESS;
      S_ACCESS: begin
        mem_addr = w_word_addr;
        if (w_do_write && (r_f3 != F3_W)) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_IDLE;
          if (w_do_write) begin
            w_mem_we = 1'b1;
            mem_wd   = r_wdata;
          end
        end
      end
      S_WRITE: begin
        mem_addr = w_word_addr;
        w_mem_we = 1'b1;
        mem_wd   = r_merged;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Reset must suppress the write the memory would take on the reset edge,
  // so an interrupted RMW leaves memory untouched.
  assign mem_we    = w_mem_we & ~RST;
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  // Store responses show 0; otherwise the last load result is held.
  assign rsp_rdata = r_rsp_st ? '0 : r_rsp_rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_f3        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merged    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_st    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_st    <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_f3    <= req_funct3;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
        end
        S_ACCESS: begin
          if (w_next == S_WRITE) begin
            r_merged <= w_st_word;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_st    <= r_we;
            if (!r_we) r_rsp_rdata <= w_err ? '0 : w_ld_data;
          end
        end
        S_WRITE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_st    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses
// (data, error, due cycle); a negedge monitor pops and compares on rsp_valid
// and logs every memory write for the write-side checks.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 CLK = ~CLK;

  load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Word memory, 64 words, combinational read, posedge write.
  logic [31:0] mem [0:63];
  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge CLK) if (mem_we) mem[mem_addr[7:2]] <= mem_wd;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [31:0] rd; logic err; int due; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  exp_t sb [$];
  wr_t  wlog [$];
  int checks = 0;
  int errors = 0;

  // Monitor
  always @(negedge CLK) begin
    exp_t e;
    if (mem_we) wlog.push_back('{mem_addr, mem_wd, cyc});
    if (mem_addr[1:0] != 2'b00) begin
      checks++; errors++;
      $display("FAIL mem_addr_align got=%h required low bits 00", mem_addr);
    end
    if (!RST) begin
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp cyc=%0d rdata=%h err=%b", cyc, rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          if (rsp_rdata !== e.rd || rsp_err !== e.err || cyc != e.due) begin
            errors++;
            $display("FAIL rsp got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                     rsp_rdata, rsp_err, cyc, e.rd, e.err, e.due);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++; errors++;
        $display("FAIL missing_rsp required rdata=%h due=%0d now=%0d", sb[0].rd, sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Present a request, wait for accept, optionally queue its expected response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input bit push, output int acc);
    exp_t e;
    int n;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge CLK);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    acc = cyc;
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h", a);
    end else if (push) begin
      e.rd = er; e.err = ee; e.due = cyc + lat;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 30) begin @(negedge CLK); n++; end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
      sb.delete();
    end
    @(posedge CLK); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[16] = 32'h8077F0A5;  // 0x40
    mem[17] = 32'h11223344;  // 0x44
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_mem_wd",    mem_wd, 32'd0);
    @(posedge CLK); #1; RST = 1'b0;

    // Loads from 0x40 = 0x8077F0A5
    issue(1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 1'b1, a0);  // LB
    drain();
    issue(1'b0, 3'b100, 32'h43, 32'h0, 32'h00000080, 1'b0, 2, 1'b1, a0);  // LBU
    drain();
    issue(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF8077, 1'b0, 2, 1'b1, a0);  // LH
    drain();

    // SB 0x45 into 0x11223344
    wlog.delete();
    issue(1'b1, 3'b000, 32'h45, 32'h000000CC, 32'h0, 1'b0, 3, 1'b1, a0);
    drain();
    chk("sb_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) begin
      chk("sb_waddr", wlog[0].addr, 32'h44);
      chk("sb_wdata", wlog[0].data, 32'h1122CC44);
      chk("sb_wcyc",  32'(wlog[0].cyc), 32'(a0 + 2));
    end
    issue(1'b0, 3'b010, 32'h44, 32'h0, 32'h1122CC44, 1'b0, 2, 1'b1, a0);  // LW
    drain();

    // SW / LW / SH / LHU at 0x80
    wlog.delete();
    issue(1'b1, 3'b010, 32'h80, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, a0);
    drain();
    chk("sw_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) begin
      chk("sw_wdata", wlog[0].data, 32'hDEADBEEF);
      chk("sw_wcyc",  32'(wlog[0].cyc), 32'(a0 + 1));
    end
    issue(1'b0, 3'b010, 32'h80, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, a0);
    drain();
    issue(1'b1, 3'b001, 32'h82, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1, a0);   // SH
    drain();
    chk("sh_mem_word", mem[32], 32'hBEEFBEEF);
    issue(1'b0, 3'b101, 32'h82, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1, a0);   // LHU
    drain();

    // Back-to-back LW, LW with req_valid held
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h8077F0A5, 1'b0, 2, 1'b1, a0);
    issue(1'b0, 3'b010, 32'h44, 32'h0, 32'h1122CC44, 1'b0, 2, 1'b1, a1);
    chk("b2b_accept_gap", 32'(a1 - a0), 32'd2);
    drain();

    // Invalid funct3: load returns 0, store writes nothing
    wlog.delete();
    issue(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b0, 2, 1'b1, a0);
    drain();
    issue(1'b1, 3'b110, 32'h44, 32'hFFFFFFFF, 32'h0, 1'b0, 2, 1'b1, a0);
    drain();
    chk("bad_f3_nwrites", 32'(wlog.size()), 32'd0);
    chk("bad_f3_mem", mem[17], 32'h1122CC44);

    // Misaligned LW 0x42
    wlog.delete();
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 2, 1'b1, a0);
    drain();
    issue(1'b1, 3'b010, 32'h42, 32'h12345678, 32'h0, 1'b1, 2, 1'b1, a0);
    drain();
    chk("misalign_nwrites", 32'(wlog.size()), 32'd0);
`else
    issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h8077F0A5, 1'b0, 2, 1'b1, a0);
    drain();
`endif

    // Reset during the WRITE cycle of SB 0x45
    wlog.delete();
    issue(1'b1, 3'b000, 32'h45, 32'h00000077, 32'h0, 1'b0, 3, 1'b0, a0);
    @(posedge CLK); #1;          // now in WRITE
    RST = 1'b1;
    @(negedge CLK);
    chk("rstw_mem_we", 32'(mem_we), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(posedge CLK);
    #1;
    chk("rstw_nwrites", 32'(wlog.size()), 32'd0);
    chk("rstw_mem", mem[17], 32'h1122CC44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-only data-memory port: sits between the core's MEM stage and data memory.
- Converts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory accesses.
- Sub-word stores use a 2-access read-modify-write; loads are byte/half extracted and sign/zero-extended.
- Core is stalled through a valid/ready handshake.

Parameters:
- ADDR_W, 32, byte-address width.
- XLEN, 32, data width (only 32 supported).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents request.
- req_ready  out  1  unit can accept; request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data (low bytes used for SB/SH).
- rsp_valid  out  1  one-cycle pulse: request complete.
- rsp_rdata  out  XLEN  load result, valid with rsp_valid (0 for stores).
- rsp_err  out  1  misalignment flag, valid with rsp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned byte address; bits [1:0] always 00.
- mem_wd  out  XLEN  memory write data.
- mem_rd  in  XLEN  memory read data, combinational from mem_addr in the same cycle.

Behaviour:
- Clock CLK; reset RST is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
- FSM states: IDLE, ACCESS, WRITE.
- IDLE:
  - req_ready=1.
  - On accept, latch we/funct3/addr/wdata and go to ACCESS.
- ACCESS:
  - mem_addr = {addr[31:2],2'b00}.
  - Load: extract from mem_rd by addr[1:0], extend per funct3, register into rsp_rdata. Go IDLE with rsp_valid=1 the next cycle.
  - SW: mem_we=1, mem_wd=wdata. Go IDLE with rsp_valid=1.
  - SB/SH: merge wdata byte/half into mem_rd at addr[1:0] / addr[1], register the merged word. Go WRITE.
- WRITE:
  - mem_we=1, mem_wd=merged word, mem_addr unchanged.
  - Go IDLE with rsp_valid=1.
- Latency from accept to rsp_valid: load 2 cycles, SW 2, SB/SH 3.
- mem_we is asserted only in ACCESS (SW) or WRITE (SB/SH), never in IDLE.
- Back-to-back: a new request may be accepted in the same IDLE cycle that rsp_valid is high.
- Invalid funct3 (load 011/110/111; store 011–111):
  - No write.
  - Load returns 0.
  - Response still issued with normal latency.
- Reset mid-operation:
  - Returns to IDLE on that edge.
  - A pending RMW write is abandoned; memory is unmodified.
  - No rsp_valid is produced for the abandoned request.
- rsp_rdata holds its value until the next load completes.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠00.
  - A misaligned request goes IDLE→ACCESS→IDLE with mem_we=0.
  - Response has rsp_err=1 and rsp_rdata=0.
- Undefined:
  - Low address bits are truncated to natural alignment: halfword uses addr[1], word ignores [1:0].
  - rsp_err is tied 0.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B/H/W/BU/HU), state enum, extract/merge lane select helpers.
- Sub-module lsu_align (combinational): load extract/extend and store merge.
- FSM and registers stay in load_store_unit.

Test Plan:
- Word 0x40 = 0x8077F0A5:
  - LB 0x40 → rsp_rdata 0xFFFFFFA5, rsp_valid 2 cycles after accept.
  - LBU 0x43 → 0x00000080.
  - LH 0x42 → 0xFFFF8077.
- Word 0x44 = 0x11223344, SB 0x45 wdata 0x000000CC:
  - mem_we exactly 1 cycle (WRITE) with mem_wd 0x1122CC44.
  - rsp_valid at cycle 3.
  - Subsequent LW 0x44 → 0x1122CC44.
- SW 0x80 0xDEADBEEF:
  - mem_we in ACCESS only.
  - LW 0x80 → 0xDEADBEEF.
  - SH 0x82 0x0000BEEF, then LHU 0x82 → 0x0000BEEF.
- req_valid held high for LW,LW: second request accepted in the cycle rsp_valid of the first is high; no idle bubble beyond IDLE.
- RST asserted during WRITE of SB 0x45 → no mem_we, word unchanged, no rsp_valid, req_ready=1 next cycle.
- LW 0x42 (word 0x40 = 0x8077F0A5):
  - With MISALIGN_TRAP_EN: rsp_err=1, rsp_rdata=0, mem_we never set.
  - Without: rsp_rdata 0x8077F0A5, rsp_err=0.
